// File: rtl/bus_simple_mux.sv
// One-master to NUM_SLAVES-slave router with address decode, decode-error and response timeout.
// Define BUS_SIMPLE_MUX_STATS_EN to add transaction and error counters.
module bus_simple_mux #(
  parameter int unsigned                NUM_SLAVES  = 4,
  parameter int unsigned                AW          = 32,
  parameter int unsigned                DW          = 32,
  parameter logic [NUM_SLAVES*AW-1:0]   SLV_BASE    = '0,
  parameter logic [NUM_SLAVES*AW-1:0]   SLV_MASK    = '0,
  parameter int unsigned                TIMEOUT_CYC = 16,
  parameter logic [DW-1:0]              ERR_RDATA   = DW'(32'hDEADBEEF)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     m_valid_i,
  input  logic                     m_write_i,
  input  logic [AW-1:0]            m_addr_i,
  input  logic [DW-1:0]            m_wdata_i,
  input  logic [DW/8-1:0]          m_wstrb_i,
  output logic                     m_ready_o,
  output logic [DW-1:0]            m_rdata_o,
  output logic                     m_rvalid_o,
  output logic                     m_err_o,
  output logic [NUM_SLAVES-1:0]    s_valid_o,
  output logic                     s_write_o,
  output logic [AW-1:0]            s_addr_o,
  output logic [DW-1:0]            s_wdata_o,
  output logic [DW/8-1:0]          s_wstrb_o,
  input  logic [NUM_SLAVES-1:0]    s_ready_i,
  input  logic [NUM_SLAVES*DW-1:0] s_rdata_i,
  input  logic [NUM_SLAVES-1:0]    s_rvalid_i
`ifdef BUS_SIMPLE_MUX_STATS_EN
  ,
  output logic [31:0]              stat_txn_cnt_o,
  output logic [31:0]              stat_err_cnt_o
`endif
);

  localparam int unsigned IdxW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q;
  logic [IdxW-1:0]         tgt_q;
  logic                    wr_q;
  logic [CntW-1:0]         cnt_q;
  logic                    m_ready_q, m_rvalid_q, m_err_q;
  logic [DW-1:0]           m_rdata_q;
  logic [NUM_SLAVES-1:0]   s_valid_q;
  logic                    s_write_q;
  logic [AW-1:0]           s_addr_q;
  logic [DW-1:0]           s_wdata_q;
  logic [DW/8-1:0]         s_wstrb_q;

  logic                    hit;
  logic [IdxW-1:0]         hit_idx;
  logic [NUM_SLAVES-1:0]   hit_oh;
  logic                    sel_ready, sel_rvalid, rsp_hit, timeout;
  logic [DW-1:0]           sel_rdata;
  logic [CntW-1:0]         cnt_inc;

  // Walk downwards so the lowest-index hit is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_oh  = '0;
    for (int k = int'(NUM_SLAVES) - 1; k >= 0; k--) begin
      if ((m_addr_i & SLV_MASK[k*AW +: AW]) == SLV_BASE[k*AW +: AW]) begin
        hit     = 1'b1;
        hit_idx = IdxW'(k);
        hit_oh  = '0;
        hit_oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_ready  = 1'b0;
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    for (int k = 0; k < int'(NUM_SLAVES); k++) begin
      if (tgt_q == IdxW'(k)) begin
        sel_ready  = s_ready_i[k];
        sel_rvalid = s_rvalid_i[k];
        sel_rdata  = s_rdata_i[k*DW +: DW];
      end
    end
  end

  assign rsp_hit = wr_q ? sel_ready : sel_rvalid;
  assign cnt_inc = cnt_q + 1'b1;
  assign timeout = (cnt_inc == CntW'(TIMEOUT_CYC));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      tgt_q      <= '0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      m_ready_q  <= 1'b0;
      m_rvalid_q <= 1'b0;
      m_err_q    <= 1'b0;
      m_rdata_q  <= '0;
      s_valid_q  <= '0;
      s_write_q  <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wstrb_q  <= '0;
    end else begin
      // Response flags and the request strobe are single-cycle pulses.
      s_valid_q  <= '0;
      m_ready_q  <= 1'b0;
      m_rvalid_q <= 1'b0;
      m_err_q    <= 1'b0;
      m_rdata_q  <= '0;
      unique case (state_q)
        StIdle: begin
          if (m_valid_i) begin
            wr_q <= m_write_i;
            if (hit) begin
              tgt_q     <= hit_idx;
              s_valid_q <= hit_oh;
              s_write_q <= m_write_i;
              s_addr_q  <= m_addr_i;
              s_wdata_q <= m_wdata_i;
              s_wstrb_q <= m_wstrb_i;
              cnt_q     <= '0;
              state_q   <= StWait;
            end else begin
              m_err_q <= 1'b1;
              if (m_write_i) begin
                m_ready_q <= 1'b1;
              end else begin
                m_rvalid_q <= 1'b1;
                m_rdata_q  <= ERR_RDATA;
              end
              state_q <= StResp;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_inc;
          if (rsp_hit) begin
            if (wr_q) begin
              m_ready_q <= 1'b1;
            end else begin
              m_rvalid_q <= 1'b1;
              m_rdata_q  <= sel_rdata;
            end
            state_q <= StResp;
          end else if (timeout) begin
            m_err_q <= 1'b1;
            if (wr_q) begin
              m_ready_q <= 1'b1;
            end else begin
              m_rvalid_q <= 1'b1;
              m_rdata_q  <= ERR_RDATA;
            end
            state_q <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign m_ready_o  = m_ready_q;
  assign m_rvalid_o = m_rvalid_q;
  assign m_err_o    = m_err_q;
  assign m_rdata_o  = m_rdata_q;
  assign s_valid_o  = s_valid_q;
  assign s_write_o  = s_write_q;
  assign s_addr_o   = s_addr_q;
  assign s_wdata_o  = s_wdata_q;
  assign s_wstrb_o  = s_wstrb_q;

`ifdef BUS_SIMPLE_MUX_STATS_EN
  logic [31:0] stat_txn_q, stat_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_txn_q <= '0;
      stat_err_q <= '0;
    end else if (state_q == StResp) begin
      stat_txn_q <= stat_txn_q + 32'd1;
      if (m_err_q) begin
        stat_err_q <= stat_err_q + 32'd1;
      end
    end
  end

  assign stat_txn_cnt_o = stat_txn_q;
  assign stat_err_cnt_o = stat_err_q;
`endif

endmodule

// File: tb/tb_bus_simple_mux.sv
// Directed self-checking bench for bus_simple_mux: decode, latency, miss, timeout, priority, reset.
module tb_bus_simple_mux;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  // Slaves 0 and 3 overlap on 0x20xx_xxxx; slave 0 is the narrower window.
  localparam logic [NS*AW-1:0] BASE = {32'h2000_0000, 32'h3000_0000, 32'h1000_0000, 32'h2000_0000};
  localparam logic [NS*AW-1:0] MASK = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFF00_0000};

  logic           clk, rst;
  logic           m_valid, m_write;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_wdata;
  logic [3:0]     m_wstrb;
  logic           m_ready, m_rvalid, m_err;
  logic [DW-1:0]  m_rdata;
  logic [NS-1:0]  s_valid;
  logic           s_write;
  logic [AW-1:0]  s_addr;
  logic [DW-1:0]  s_wdata;
  logic [3:0]     s_wstrb;
  logic [NS-1:0]  s_ready, s_rvalid;
  logic [NS*DW-1:0] s_rdata;
`ifdef BUS_SIMPLE_MUX_STATS_EN
  logic [31:0]    stat_txn, stat_err;
`endif

  int errors = 0;
  int checks = 0;

  bus_simple_mux #(
    .NUM_SLAVES (NS),
    .AW         (AW),
    .DW         (DW),
    .SLV_BASE   (BASE),
    .SLV_MASK   (MASK),
    .TIMEOUT_CYC(16),
    .ERR_RDATA  (32'hDEADBEEF)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .m_valid_i (m_valid),
    .m_write_i (m_write),
    .m_addr_i  (m_addr),
    .m_wdata_i (m_wdata),
    .m_wstrb_i (m_wstrb),
    .m_ready_o (m_ready),
    .m_rdata_o (m_rdata),
    .m_rvalid_o(m_rvalid),
    .m_err_o   (m_err),
    .s_valid_o (s_valid),
    .s_write_o (s_write),
    .s_addr_o  (s_addr),
    .s_wdata_o (s_wdata),
    .s_wstrb_o (s_wstrb),
    .s_ready_i (s_ready),
    .s_rdata_i (s_rdata),
    .s_rvalid_i(s_rvalid)
`ifdef BUS_SIMPLE_MUX_STATS_EN
    ,
    .stat_txn_cnt_o(stat_txn),
    .stat_err_cnt_o(stat_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_valid = 1'b1; m_write = 1'b1; m_addr = 32'h1000_0000;
    m_wdata = 32'h5555_5555; m_wstrb = 4'hF;
    s_ready = '0; s_rvalid = '0; s_rdata = '0;
    step(); step();
    checks++; if ({m_ready, m_rvalid, m_err} !== 3'b000) begin
      errors++; $display("FAIL rst_flags: got %b want 000", {m_ready, m_rvalid, m_err}); end
    checks++; if (m_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_rdata: got %h want 00000000", m_rdata); end
    checks++; if (s_valid !== 4'b0000) begin
      errors++; $display("FAIL rst_svalid: got %b want 0000", s_valid); end
    checks++; if ({s_write, s_addr, s_wdata, s_wstrb} !== 69'h0) begin
      errors++; $display("FAIL rst_sfields: got %h want 0", {s_write, s_addr, s_wdata, s_wstrb}); end
    rst = 1'b0; m_valid = 1'b0;
    step();
  endtask

  task automatic test_write();
    m_valid = 1'b1; m_write = 1'b1; m_addr = 32'h1000_0004;
    m_wdata = 32'h1122_3344; m_wstrb = 4'hF;
    step();  // T+1
    checks++; if (s_valid !== 4'b0010) begin
      errors++; $display("FAIL wr_svalid: got %b want 0010", s_valid); end
    checks++; if ({s_write, s_addr, s_wdata, s_wstrb} !== {1'b1, 32'h1000_0004, 32'h1122_3344, 4'hF})
      begin errors++; $display("FAIL wr_sfields: got %h", {s_write, s_addr, s_wdata, s_wstrb}); end
    step();  // T+2
    checks++; if ({s_valid, m_ready} !== 5'b0) begin
      errors++; $display("FAIL wr_t2: got %b want 00000", {s_valid, m_ready}); end
    s_ready = 4'b0010;
    step();  // T+3
    s_ready = '0; m_valid = 1'b0;
    checks++; if ({m_ready, m_err, m_rvalid} !== 3'b100) begin
      errors++; $display("FAIL wr_resp: got %b want 100", {m_ready, m_err, m_rvalid}); end
    step();
    checks++; if (m_ready !== 1'b0) begin
      errors++; $display("FAIL wr_pulse: got %b want 0", m_ready); end
  endtask

  task automatic test_read_latency();
    m_valid = 1'b1; m_write = 1'b0; m_addr = 32'h3000_0020;
    step();  // T+1
    checks++; if ({s_valid, s_write} !== 5'b01000) begin
      errors++; $display("FAIL rd_svalid: got %b want 01000", {s_valid, s_write}); end
    for (int i = 2; i <= 6; i++) begin
      step();
      checks++; if ({s_valid, m_rvalid} !== 5'b0) begin
        errors++; $display("FAIL rd_wait%0d: got %b want 00000", i, {s_valid, m_rvalid}); end
    end
    s_rvalid = 4'b0100; s_rdata[2*DW +: DW] = 32'hCAFE_F00D; s_rdata[1*DW +: DW] = 32'h1111_1111;
    step();  // T+7
    s_rvalid = '0; m_valid = 1'b0;
    checks++; if ({m_rvalid, m_err, m_ready} !== 3'b100) begin
      errors++; $display("FAIL rd_flags: got %b want 100", {m_rvalid, m_err, m_ready}); end
    checks++; if (m_rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL rd_data: got %h want cafef00d", m_rdata); end
    step();
  endtask

  task automatic test_decode_miss();
    m_valid = 1'b1; m_write = 1'b0; m_addr = 32'h9000_0000;
    step();  // T+1
    m_valid = 1'b0;
    checks++; if ({m_rvalid, m_err} !== 2'b11) begin
      errors++; $display("FAIL miss_flags: got %b want 11", {m_rvalid, m_err}); end
    checks++; if (m_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL miss_data: got %h want deadbeef", m_rdata); end
    checks++; if (s_valid !== 4'b0000 || s_addr !== 32'h3000_0020) begin
      errors++; $display("FAIL miss_noacc: got %b/%h want 0000/30000020", s_valid, s_addr); end
    step();
    checks++; if (m_rvalid !== 1'b0) begin
      errors++; $display("FAIL miss_pulse: got %b want 0", m_rvalid); end
  endtask

  task automatic test_timeout();
    m_valid = 1'b1; m_write = 1'b1; m_addr = 32'h1000_0008; m_wdata = 32'h0F0F_0F0F;
    step();  // T+1
    checks++; if (s_valid !== 4'b0010) begin
      errors++; $display("FAIL to_svalid: got %b want 0010", s_valid); end
    for (int i = 2; i <= 16; i++) begin
      step();
      checks++; if ({m_ready, m_rvalid} !== 2'b00) begin
        errors++; $display("FAIL to_wait%0d: got %b want 00", i, {m_ready, m_rvalid}); end
    end
    step();  // T+17
    m_valid = 1'b0;
    checks++; if ({m_ready, m_err} !== 2'b11) begin
      errors++; $display("FAIL to_resp: got %b want 11", {m_ready, m_err}); end
    step(); step(); step();  // T+20
    s_ready = 4'b0010;
    step();
    s_ready = '0;
    for (int i = 21; i <= 22; i++) begin
      checks++; if ({m_ready, m_rvalid, s_valid} !== 6'b0) begin
        errors++; $display("FAIL to_late%0d: got %b want 0", i, {m_ready, m_rvalid, s_valid}); end
      step();
    end
  endtask

  task automatic test_priority();
    m_valid = 1'b1; m_write = 1'b0; m_addr = 32'h2000_0010;
    step();  // T+1
    checks++; if (s_valid !== 4'b0001) begin
      errors++; $display("FAIL pri_svalid: got %b want 0001", s_valid); end
    step();  // T+2: wrong slave and wrong response type
    s_rvalid = 4'b1000; s_rdata[3*DW +: DW] = 32'hBAD0_BAD0; s_ready = 4'b0001;
    step();  // T+3
    checks++; if ({m_rvalid, m_ready} !== 2'b00) begin
      errors++; $display("FAIL pri_spur: got %b want 00", {m_rvalid, m_ready}); end
    s_ready = '0; s_rvalid = 4'b0001; s_rdata[0 +: DW] = 32'h1234_5678;
    step();  // T+4
    s_rvalid = '0; m_valid = 1'b0;
    checks++; if ({m_rvalid, m_err} !== 2'b10 || m_rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL pri_resp: got %b/%h want 10/12345678", {m_rvalid, m_err}, m_rdata);
    end
    step();
  endtask

  task automatic test_zero_cycle();
    m_valid = 1'b1; m_write = 1'b1; m_addr = 32'h2100_0000; m_wdata = 32'hA5A5_A5A5; m_wstrb = 4'h0;
    step();  // T+1
    checks++; if (s_valid !== 4'b1000 || s_wstrb !== 4'h0) begin
      errors++; $display("FAIL zc_req: got %b/%h want 1000/0", s_valid, s_wstrb); end
    s_ready = 4'b1000;
    step();  // T+2
    s_ready = '0; m_valid = 1'b0;
    checks++; if ({m_ready, m_err} !== 2'b10) begin
      errors++; $display("FAIL zc_resp: got %b want 10", {m_ready, m_err}); end
    step();
`ifdef BUS_SIMPLE_MUX_STATS_EN
    checks++; if (stat_txn !== 32'd6 || stat_err !== 32'd2) begin
      errors++; $display("FAIL stats: got %0d/%0d want 6/2", stat_txn, stat_err); end
`endif
  endtask

  task automatic test_reset_in_wait();
    m_valid = 1'b1; m_write = 1'b0; m_addr = 32'h3000_0000;
    step(); step();  // T+2, in WAIT
    rst = 1'b1; m_valid = 1'b0;
    step();  // T+3
    rst = 1'b0;
    checks++; if ({m_ready, m_rvalid, m_err, s_valid} !== 7'b0 || s_addr !== 32'h0) begin
      errors++; $display("FAIL rw_clear: got %b/%h want 0/0", {m_ready, m_rvalid, m_err, s_valid}, s_addr);
    end
    s_rvalid = 4'b0100; s_rdata[2*DW +: DW] = 32'h7777_7777;
    step();
    s_rvalid = '0;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({m_ready, m_rvalid, s_valid} !== 6'b0) begin
        errors++; $display("FAIL rw_late%0d: got %b want 0", i, {m_ready, m_rvalid, s_valid}); end
      step();
    end
`ifdef BUS_SIMPLE_MUX_STATS_EN
    checks++; if (stat_txn !== 32'd0 || stat_err !== 32'd0) begin
      errors++; $display("FAIL stats_rst: got %0d/%0d want 0/0", stat_txn, stat_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_latency();
    test_decode_miss();
    test_timeout();
    test_priority();
    test_zero_cycle();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
